// File: rtl/usr_deserializer.sv
// Purpose : serial-to-parallel receiver for a universal shift register's SO stream,
//           MSB-first or LSB-first, with a held parallel word and valid/ready handshake.
// Latency : the completed word appears on PO with valid=1 right after the edge that samples its last bit.
// Backpr. : a word completing while valid=1 and ready=0 is dropped and sets the sticky overrun flag.
//
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   SI, en         - serial bit and its strobe (one bit per en cycle while busy)
//   start, dir     - begin a frame (IDLE only); dir=0 MSB-first, dir=1 LSB-first
//   ready          - consumer accepts PO when valid=1
//   PO, valid      - last completed word and its unconsumed flag
//   busy, overrun  - frame in progress; sticky "word dropped" flag
module usr_deserializer #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             SI,
    input  logic             en,
    input  logic             start,
    input  logic             dir,
    input  logic             ready,
    output logic [WIDTH-1:0] PO,
    output logic             valid,
    output logic             busy,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RECV = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sr;
    logic [CW-1:0]    r_cnt;
    logic             r_dir_q;
    logic [WIDTH-1:0] r_po;
    logic             r_valid;
    logic             r_busy;
    logic             r_overrun;

    // Shift register contents after consuming the current SI bit.
    logic [WIDTH-1:0] w_sr_next;

    always_comb begin
        w_sr_next = r_sr;
        if (r_dir_q) begin
            w_sr_next = {SI, r_sr[WIDTH-1:1]};
        end else begin
            w_sr_next = {r_sr[WIDTH-2:0], SI};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_sr      <= '0;
            r_cnt     <= '0;
            r_dir_q   <= 1'b0;
            r_po      <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            // Plain handshake; a completion on the same edge overrides this below.
            if (r_valid && ready) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    // en and SI are deliberately ignored here, including on the start cycle.
                    if (start) begin
                        r_state <= S_RECV;
                        r_busy  <= 1'b1;
                        r_dir_q <= dir;
                        r_sr    <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_RECV: begin
                    if (en) begin
                        r_sr <= w_sr_next;
                        if (r_cnt == LAST_BIT) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_cnt   <= '0;
                            // A word consumed on this edge frees the slot for the new one.
                            if (!r_valid || ready) begin
                                r_po    <= w_sr_next;
                                r_valid <= 1'b1;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign PO      = r_po;
    assign valid   = r_valid;
    assign busy    = r_busy;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_usr_deserializer.sv
module tb_usr_deserializer;

    logic       clk;
    logic       rst;
    logic       SI;
    logic       en;
    logic       start;
    logic       dir;
    logic       ready;
    logic [4:0] PO;
    logic       valid;
    logic       busy;
    logic       overrun;

    int checks   = 0;
    int failures = 0;

    usr_deserializer #(.WIDTH(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .SI      (SI),
        .en      (en),
        .start   (start),
        .dir     (dir),
        .ready   (ready),
        .PO      (PO),
        .valid   (valid),
        .busy    (busy),
        .overrun (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One start cycle then five consecutive strobed bits; seq[4] is sent first.
    // ready is driven to rdy_last only on the completion cycle.
    task automatic frame(input logic d, input logic [4:0] seq, input logic rdy_last);
        start = 1'b1;
        dir   = d;
        en    = 1'b1;
        SI    = 1'($urandom);
        tick();
        start = 1'b0;
        dir   = 1'($urandom);
        for (int i = 4; i >= 0; i--) begin
            en = 1'b1;
            SI = seq[i];
            if (i == 0) ready = rdy_last;
            tick();
        end
        en    = 1'b0;
        ready = 1'b0;
    endtask

    task automatic consume();
        ready = 1'b1;
        en    = 1'b0;
        tick();
        ready = 1'b0;
    endtask

    logic [4:0] gap_seq;
    logic [4:0] lb_q;

    initial begin
        rst = 1'b1; SI = 1'b0; en = 1'b0; start = 1'b0; dir = 1'b0; ready = 1'b0;

        // Reset with random inputs
        for (int i = 0; i < 2; i++) begin
            SI = 1'($urandom); en = 1'($urandom); start = 1'($urandom);
            dir = 1'($urandom); ready = 1'($urandom);
            tick();
        end
        chk("rst_po", 32'(PO), 32'h00);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        rst = 1'b0; SI = 1'b0; en = 1'b0; start = 1'b0; dir = 1'b0; ready = 1'b0;
        tick();

        // MSB-first 1,0,1,1,0
        start = 1'b1; dir = 1'b0; en = 1'b1; SI = 1'b1;
        tick();
        chk("msb_busy_after_start", 32'(busy), 32'h1);
        start = 1'b0;
        for (int i = 4; i >= 0; i--) begin
            en = 1'b1;
            SI = 5'b10110 >> i;
            tick();
            if (i == 1) begin
                chk("msb_not_valid_after_4", 32'(valid), 32'h0);
                chk("msb_busy_after_4", 32'(busy), 32'h1);
            end
        end
        en = 1'b0;
        chk("msb_po", 32'(PO), 32'h16);
        chk("msb_valid", 32'(valid), 32'h1);
        chk("msb_busy_done", 32'(busy), 32'h0);
        consume();
        chk("msb_valid_consumed", 32'(valid), 32'h0);
        chk("msb_po_held", 32'(PO), 32'h16);

        // LSB-first 1,0,1,1,0
        frame(1'b1, 5'b10110, 1'b0);
        chk("lsb_po", 32'(PO), 32'h0D);
        chk("lsb_valid", 32'(valid), 32'h1);
        consume();

        // Loopback from a shift-right register loaded with 10011
        lb_q = 5'b10011;
        start = 1'b1; dir = 1'b1; en = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            en   = 1'b1;
            SI   = lb_q[0];
            lb_q = lb_q >> 1;
            tick();
        end
        en = 1'b0;
        chk("loopback_po", 32'(PO), 32'h13);
        consume();

        // Gapped strobe 1,1,0,0,1 MSB-first; SI toggles and start/dir=1 are poked during gaps
        gap_seq = 5'b11001;
        start = 1'b1; dir = 1'b0; en = 1'b0;
        tick();
        for (int i = 4; i >= 0; i--) begin
            en = 1'b1; start = 1'b0; dir = 1'b0;
            SI = gap_seq[i];
            tick();
            if (i != 0) begin
                for (int g = 0; g < 2; g++) begin
                    en = 1'b0; start = 1'b1; dir = 1'b1;
                    SI = ~SI;
                    tick();
                end
                start = 1'b0;
            end
            if (i == 1) begin
                chk("gap_not_valid_after_4", 32'(valid), 32'h0);
                chk("gap_busy_after_4", 32'(busy), 32'h1);
            end
        end
        en = 1'b0; start = 1'b0; dir = 1'b0;
        chk("gap_po", 32'(PO), 32'h19);
        chk("gap_valid", 32'(valid), 32'h1);
        chk("gap_busy_done", 32'(busy), 32'h0);
        consume();

        // Overrun: ready held low across two completions
        frame(1'b0, 5'b10110, 1'b0);
        frame(1'b0, 5'b00011, 1'b0);
        chk("ovr_po", 32'(PO), 32'h16);
        chk("ovr_overrun", 32'(overrun), 32'h1);
        chk("ovr_valid", 32'(valid), 32'h1);

        // Reset clears overrun; then ready exactly at the second completion edge
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("ovr_cleared_by_rst", 32'(overrun), 32'h0);
        frame(1'b0, 5'b10110, 1'b0);
        frame(1'b0, 5'b00011, 1'b1);
        chk("simul_po", 32'(PO), 32'h03);
        chk("simul_valid", 32'(valid), 32'h1);
        chk("simul_overrun", 32'(overrun), 32'h0);

        // Reset mid-frame after three 1 bits
        start = 1'b1; dir = 1'b0; en = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            en = 1'b1; SI = 1'b1;
            tick();
        end
        en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_valid", 32'(valid), 32'h0);
        frame(1'b0, 5'b00001, 1'b0);
        chk("midrst_po", 32'(PO), 32'h01);
        chk("midrst_valid_new", 32'(valid), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/usr_deserializer.md
# usr_deserializer

Serial-to-parallel receiver for the serial stream produced by the universal shift register's `SO` output. It collects `WIDTH` serial bits under a bit-enable strobe, either MSB-first (pairs with the register's shift-left mode) or LSB-first (pairs with its shift-right mode). It presents the assembled word on a held parallel output with a valid/ready handshake. It sits at the far end of the serial link and rebuilds the words loaded into the transmitting register through `PI`.

## Interface

Parameters:
- `WIDTH`, default 5: word width in bits, must be ≥ 2.

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `SI`, input, 1: serial data in, sampled only when `en`=1 in RECV.
- `en`, input, 1: bit strobe; one bit is consumed per cycle with `en`=1.
- `start`, input, 1: begin a frame; honoured only in IDLE.
- `dir`, input, 1: bit order, latched at `start`.
  - 0 = MSB-first: first bit lands in `PO[WIDTH-1]`.
  - 1 = LSB-first: first bit lands in `PO[0]`.
- `ready`, input, 1: consumer accepts the word.
- `PO`, output, `WIDTH`: last completed word, held until replaced.
- `valid`, output, 1: `PO` holds an unconsumed word.
- `busy`, output, 1: frame in progress (state == RECV).
- `overrun`, output, 1: sticky; a completed word was dropped.

## Operation

- FSM states:
  - IDLE: `start`=1 moves to RECV, latches `dir` into `dir_q`, and clears the shift register and bit counter. `en` and `SI` are ignored in IDLE, including on the `start` cycle.
  - RECV: each cycle with `en`=1 shifts in one bit and increments the counter.
    - `dir_q`=0: `sr <= {sr[WIDTH-2:0], SI}`.
    - `dir_q`=1: `sr <= {SI, sr[WIDTH-1:1]}`.
    - `en`=0 holds `sr` and the counter.
    - `start` is ignored in RECV.
  - Completion: when `en`=1 and the counter == `WIDTH-1`, the post-shift word is the completed word and the FSM returns to IDLE.
- Counter: width `$clog2(WIDTH)`, counts 0..`WIDTH-1`, cleared on `start` and on completion; never wraps silently.
- Output register, at the completion edge:
  - If `valid`=0, or `valid`=1 with `ready`=1: `PO` ← completed word, `valid` ← 1.
  - If `valid`=1 with `ready`=0: the completed word is dropped, `PO` is unchanged, `valid` stays 1, `overrun` ← 1.
- Handshake: a transfer occurs at any edge with `valid`=1 and `ready`=1. With no simultaneous completion, `valid` ← 0 and `PO` holds its value.
- `overrun` is cleared only by `rst`.
- Reset values: `PO`=0, `valid`=0, `busy`=0, `overrun`=0, state=IDLE, `sr`=0, counter=0, `dir_q`=0.
- Reset mid-frame aborts the frame. No partial bits survive into the next frame.

## Timing

- `start` at edge k puts the block in RECV (`busy`=1) after edge k. The first bit can be sampled at edge k+1.
- With `en` held high, the first bit is at edge k+1 and the last bit at edge k+`WIDTH`.
  - `valid`=1 and `busy`=0 after edge k+`WIDTH`.
  - Latency from the last bit to `valid` is zero cycles beyond the sampling edge.
- `start` may be asserted in the same cycle that completion returns the FSM to IDLE; it is honoured on the next cycle.
- Minimum frame period is `WIDTH`+1 cycles (the `start` cycle plus `WIDTH` bit cycles).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan

Scenarios use `WIDTH`=5.

- Reset: assert `rst` for 2 cycles with random inputs → `PO`=0, `valid`=0, `busy`=0, `overrun`=0.
- MSB-first: `start` with `dir`=0, then bits 1,0,1,1,0 on 5 consecutive `en` cycles → `PO`=5'b10110 and `valid`=1 after the 5th edge. Then `ready`=1 for one cycle → `valid`=0, `PO` still 10110.
- LSB-first: `start` with `dir`=1, bits 1,0,1,1,0 → `PO`=5'b01101. Loopback: a shift register loaded with `PI`=5'b10011 and shifted right feeds its `SO` → `PO`=10011.
- Gapped strobe: `dir`=0, bits 1,1,0,0,1 with `en`=0 cycles between them, `SI` toggling during the gaps → `PO`=5'b11001, completion only after the 5th strobe.
- Overrun and simultaneous completion:
  - `ready`=0, receive 10110 then 00011 → `PO`=10110, `overrun`=1, `valid`=1.
  - Repeat after reset with `ready`=1 exactly at the second completion edge → `PO`=00011, `valid`=1, `overrun`=0.
- Reset mid-frame: after 3 bits (1,1,1), pulse `rst` → `busy`=0. A fresh `dir`=0 frame with bits 0,0,0,0,1 → `PO`=5'b00001, with no residue from the aborted frame.
